// File: rtl/periph_pkg.sv
`default_nettype none
// ============================================================================
// periph_pkg : register map and CTRL field layout shared by the CPU-bus timer
// Revision   : 1.0
// ============================================================================
package periph_pkg;

    localparam logic [2:0] TMR_CTRL      = 3'd0;
    localparam logic [2:0] TMR_STATUS    = 3'd1;
    localparam logic [2:0] TMR_RELOAD_LO = 3'd2;
    localparam logic [2:0] TMR_RELOAD_HI = 3'd3;
    localparam logic [2:0] TMR_COUNT_LO  = 3'd4;
    localparam logic [2:0] TMR_COUNT_HI  = 3'd5;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_AUTO     = 1;
    localparam int CTRL_IE       = 2;
    localparam int CTRL_LOAD     = 3;
    localparam int CTRL_PSEL_LSB = 4;
    localparam int CTRL_PSEL_MSB = 6;

    typedef struct packed {
        logic       rsvd;
        logic [2:0] psel;
        logic       load;
        logic       ie;
        logic       auto_rl;
        logic       en;
    } tmr_ctrl_t;

    function automatic logic [2:0] clamp_psel(input logic [2:0] req, input logic [2:0] max_sel);
        return (req > max_sel) ? max_sel : req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// timer_prescaler : 8-bit power-of-two prescaler, one tick per 2**psel cycles
// Revision        : 1.0
// ============================================================================
module timer_prescaler (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_i,
    input  logic [2:0] psel_i,
    input  logic       clear_i,
    output logic       tick_o
);

    logic [7:0] presc_q;
    logic [7:0] presc_d;
    logic [7:0] terminal;

    always_comb begin
        terminal = (8'd1 << psel_i) - 8'd1;
        tick_o   = enable_i && (presc_q == terminal);
        presc_d  = presc_q;
        if (clear_i || tick_o) begin
            presc_d = 8'd0;
        end else if (enable_i) begin
            presc_d = presc_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= 8'd0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/interval_timer.sv
`default_nettype none
// ============================================================================
// interval_timer : 16-bit down-counting interval timer, one-shot/auto-reload
//                  Optional macro INTERVAL_TIMER_READ_LATCH_EN: tear-free COUNT_HI
// Revision       : 1.0
// ============================================================================
module interval_timer
    import periph_pkg::*;
#(
    parameter logic [15:0] RESET_RELOAD     = 16'hFFFF,
    parameter int unsigned PRESCALE_SEL_MAX = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    input  logic       cs,
    input  logic       rwb,
    output logic       irq_out
);

    localparam logic [2:0] PSEL_MAX = 3'((PRESCALE_SEL_MAX > 7) ? 7 : PRESCALE_SEL_MAX);

    logic [2:0]  wr_addr_q;
    logic [7:0]  wr_data_q;
    logic        wr_tog_q;
    logic        wr_ack_q;
    logic        wr_pend;

    tmr_ctrl_t   ctrl_q, ctrl_d;
    logic        exp_q, exp_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;
    logic        irq_q, irq_d;
    logic        load;
    logic        psel_chg;
    logic        tick;
    logic [7:0]  rd_data;

    // Falling-edge capture keeps the commit edge free of mid-cycle i_data changes.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            wr_addr_q <= 3'd0;
            wr_data_q <= 8'd0;
            wr_tog_q  <= 1'b0;
        end else if (cs && !rwb) begin
            wr_addr_q <= addr;
            wr_data_q <= i_data;
            wr_tog_q  <= ~wr_ack_q;
        end
    end

    assign wr_pend = wr_tog_q ^ wr_ack_q;

    timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable_i (ctrl_q.en),
        .psel_i   (ctrl_q.psel),
        .clear_i  (load || psel_chg),
        .tick_o   (tick)
    );

    always_comb begin
        ctrl_d   = ctrl_q;
        exp_d    = exp_q;
        reload_d = reload_q;
        count_d  = count_q;
        load     = 1'b0;
        psel_chg = 1'b0;
        if (wr_pend) begin
            case (wr_addr_q)
                TMR_CTRL: begin
                    ctrl_d.en      = wr_data_q[CTRL_EN];
                    ctrl_d.auto_rl = wr_data_q[CTRL_AUTO];
                    ctrl_d.ie      = wr_data_q[CTRL_IE];
                    ctrl_d.psel    = clamp_psel(wr_data_q[CTRL_PSEL_MSB:CTRL_PSEL_LSB], PSEL_MAX);
                    psel_chg       = (ctrl_d.psel != ctrl_q.psel);
                    load           = wr_data_q[CTRL_LOAD];
                end
                TMR_STATUS:    if (wr_data_q[0]) exp_d = 1'b0;
                TMR_RELOAD_LO: reload_d[7:0]  = wr_data_q;
                TMR_RELOAD_HI: reload_d[15:8] = wr_data_q;
                default: ;
            endcase
        end
        // Expiry is applied after the bus write so a same-cycle clear loses.
        if (load) begin
            count_d = reload_q;
        end else if (tick) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else begin
                exp_d = 1'b1;
                if (ctrl_q.auto_rl) begin
                    count_d = reload_q;
                end else begin
                    ctrl_d.en = 1'b0;
                end
            end
        end
        irq_d = exp_d && ctrl_d.ie;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ack_q <= 1'b0;
            ctrl_q   <= '0;
            exp_q    <= 1'b0;
            reload_q <= RESET_RELOAD;
            count_q  <= 16'h0000;
            irq_q    <= 1'b0;
        end else begin
            wr_ack_q <= wr_tog_q;
            ctrl_q   <= ctrl_d;
            exp_q    <= exp_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

`ifdef INTERVAL_TIMER_READ_LATCH_EN
    logic [7:0] shadow_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= 8'h00;
        end else if (cs && rwb && (addr == TMR_COUNT_LO)) begin
            shadow_q <= count_q[15:8];
        end
    end
`endif

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            TMR_CTRL:      rd_data = ctrl_q;
            TMR_STATUS:    rd_data = {7'd0, exp_q};
            TMR_RELOAD_LO: rd_data = reload_q[7:0];
            TMR_RELOAD_HI: rd_data = reload_q[15:8];
            TMR_COUNT_LO:  rd_data = count_q[7:0];
`ifdef INTERVAL_TIMER_READ_LATCH_EN
            TMR_COUNT_HI:  rd_data = shadow_q;
`else
            TMR_COUNT_HI:  rd_data = count_q[15:8];
`endif
            default: ;
        endcase
    end

    assign o_data  = reset ? rd_data : 8'h00;
    assign irq_out = irq_q;

endmodule
`default_nettype wire
